// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback arbiter: default sizes,
// address/data types, the writeback request record and the round-robin pointer.
package regfile_pkg;

  localparam int WIDTH_DEFAULT = 64;
  localparam int DEPTH_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(DEPTH_DEFAULT);

  typedef logic [AW_DEFAULT-1:0]    reg_addr_t;
  typedef logic [WIDTH_DEFAULT-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  // Which requester wins when both are valid.
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } rr_ptr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. A grant is only given to a requester that is
// presenting a request, so the grant vector doubles as the ready vector and is
// one-hot or zero. The pointer moves to the loser after any grant.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       stall,
  input  rr_ptr_t    ptr,
  output logic [1:0] grant,
  output rr_ptr_t    ptr_next
);

  // Grant selection and next-pointer computation.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant    = 2'b00;
    ptr_next = ptr;
    if (!stall) begin
      if (valid[0] && (!valid[1] || ptr == PRI0)) begin
        grant = 2'b01;
      end else if (valid[1]) begin
        grant = 2'b10;
      end
    end
    if (grant[0]) begin
      ptr_next = PRI1;
    end else if (grant[1]) begin
      ptr_next = PRI0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the integer register file: picks one of two writeback
// requesters per cycle, registers the winning write (x0 writes are swallowed)
// and keeps a per-register pending-write scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_stall,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  output logic [DEPTH-1:0] busy,
  output logic             regwrite,
  output logic [AW-1:0]    adr_wr_reg,
  output logic [WIDTH-1:0] wr_data
);

  rr_ptr_t          ptr_q, ptr_d;
  logic             regwrite_q, regwrite_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] set_mask, clr_mask;
  logic [1:0]       grant;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;

  // Reset is folded into the stall so nothing is accepted while it is held.
  rr_arb2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .stall    (wb_stall | ~rst),
    .ptr      (ptr_q),
    .grant    (grant),
    .ptr_next (ptr_d)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Next write-port values and scoreboard update; a set beats a clear on the same register.
  always_comb begin
    regwrite_d = 1'b0;
    adr_d      = adr_q;
    data_d     = data_q;
    set_mask   = '0;
    clr_mask   = '0;
    win_addr   = grant[1] ? req1_addr : req0_addr;
    win_data   = grant[1] ? req1_data : req0_data;
    if ((|grant) && (win_addr != '0)) begin
      regwrite_d = 1'b1;
      adr_d      = win_addr;
      data_d     = win_data;
      clr_mask   = DEPTH'(1) << win_addr;
    end
    if (rsv_valid && (rsv_addr != '0)) begin
      set_mask = DEPTH'(1) << rsv_addr;
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      ptr_q      <= PRI0;
      regwrite_q <= 1'b0;
      adr_q      <= '0;
      data_q     <= '0;
      busy_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      regwrite_q <= regwrite_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign regwrite   = regwrite_q;
  assign adr_wr_reg = adr_q;
  assign wr_data    = data_q;

endmodule
